// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_pkg
// Description : Shared definitions for the operand stack and the control unit
//               that drives it: default geometry, push-data select constants
//               and the stack-count type.
// Contents    : STACK_DEPTH, DATA_W  - default entry count / data width
//               SRC_ALU, SRC_MDR     - stack_src encodings
//               COUNT_W, count_t     - occupancy counter width / type
// Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int STACK_DEPTH = 8;
    localparam int DATA_W      = 8;

    // stack_src encodings, also used by the control unit
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MDR = 1'b1;

    // One extra bit so that a completely full stack (count == DEPTH) fits
    localparam int COUNT_W = $clog2(STACK_DEPTH) + 1;
    typedef logic [COUNT_W-1:0] count_t;

endpackage : stack_pkg
`default_nettype wire

// File: rtl/operand_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_stack_if
// Description : Control-unit <-> operand-stack signal bundle.
// Ports       : push, pop, stack_src, alu_result, mdr_data, err_clr
//                   driven by the control unit (master)
//               tos, nos, count, empty, full, overflow, underflow
//                   driven by the stack (slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_stack_if #(
    parameter int WIDTH = stack_pkg::DATA_W,
    parameter int DEPTH = stack_pkg::STACK_DEPTH
);

    logic                     push;
    logic                     pop;
    logic                     stack_src;
    logic [WIDTH-1:0]         alu_result;
    logic [WIDTH-1:0]         mdr_data;
    logic                     err_clr;

    logic [WIDTH-1:0]         tos;
    logic [WIDTH-1:0]         nos;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output push, pop, stack_src, alu_result, mdr_data, err_clr,
        input  tos, nos, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, stack_src, alu_result, mdr_data, err_clr,
        output tos, nos, count, empty, full, overflow, underflow
    );

endinterface : operand_stack_if
`default_nettype wire

// File: rtl/stack_regfile.sv
`default_nettype none
// ============================================================================
// Module      : stack_regfile
// Description : DEPTH x WIDTH register array for the operand stack. One
//               synchronous write port, two asynchronous read ports.
// Ports       : clk, reset (async, active-low)
//               wr_en, wr_idx, wr_data   - write port
//               top_idx  -> top_data     - read port A (top of stack)
//               nos_idx  -> nos_data     - read port B (next on stack)
// Revision    : 1.0 - initial release
// ============================================================================
module stack_regfile #(
    parameter int DEPTH = stack_pkg::STACK_DEPTH,
    parameter int WIDTH = stack_pkg::DATA_W
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     wr_en,
    input  wire logic [$clog2(DEPTH)-1:0] wr_idx,
    input  wire logic [WIDTH-1:0]         wr_data,
    input  wire logic [$clog2(DEPTH)-1:0] top_idx,
    input  wire logic [$clog2(DEPTH)-1:0] nos_idx,
    output logic      [WIDTH-1:0]         top_data,
    output logic      [WIDTH-1:0]         nos_data
);

    import stack_pkg::*;

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    // DEPTH is a power of two, so every index value addresses a real entry
    assign top_data = r_mem[top_idx];
    assign nos_data = r_mem[nos_idx];

endmodule : stack_regfile
`default_nettype wire

// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
// Module      : operand_stack
// Description : Hardware operand stack for the 8-bit multicycle stack CPU.
//               Handles push / pop / replace-top, selects push data from the
//               ALU or the MDR, and exposes top / next-on-stack, occupancy
//               and sticky overflow / underflow flags.
// Ports       : clk    - rising-edge clock
//               reset  - asynchronous, active-low reset
//               bus    - operand_stack_if.slave (strobes in, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module operand_stack #(
    parameter int DEPTH = stack_pkg::STACK_DEPTH,
    parameter int WIDTH = stack_pkg::DATA_W
) (
    input  wire logic       clk,
    input  wire logic       reset,
    operand_stack_if.slave  bus
);

    import stack_pkg::*;

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_do_replace;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_wr_en;
    logic [IW-1:0]    w_wr_idx;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_nos_idx;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rd_top;
    logic [WIDTH-1:0] w_rd_nos;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // Index arithmetic wraps modulo DEPTH; the wrapped values for a short
    // stack are masked on the outputs below.
    assign w_top_idx = r_count[IW-1:0] - IW'(1);
    assign w_nos_idx = r_count[IW-1:0] - IW'(2);

    assign w_wdata = (bus.stack_src == SRC_MDR) ? bus.mdr_data : bus.alu_result;

    // push+pop on a non-empty stack is a replace (never an error, even when
    // full); on an empty stack it degenerates to a plain push.
    always_comb begin
        w_do_replace = 1'b0;
        w_do_push    = 1'b0;
        w_do_pop     = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        if (bus.push && bus.pop && !w_empty) begin
            w_do_replace = 1'b1;
        end else if (bus.push) begin
            w_do_push = !w_full;
            w_set_ovf = w_full;
        end else if (bus.pop) begin
            w_do_pop  = !w_empty;
            w_set_unf = w_empty;
        end
    end

    assign w_wr_en  = w_do_push | w_do_replace;
    assign w_wr_idx = w_do_replace ? w_top_idx : r_count[IW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    // A new error event in the same cycle as err_clr leaves the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_set_ovf | (r_overflow  & ~bus.err_clr);
            r_underflow <= w_set_unf | (r_underflow & ~bus.err_clr);
        end
    end

    stack_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_wr_en),
        .wr_idx   (w_wr_idx),
        .wr_data  (w_wdata),
        .top_idx  (w_top_idx),
        .nos_idx  (w_nos_idx),
        .top_data (w_rd_top),
        .nos_data (w_rd_nos)
    );

    assign bus.tos       = w_empty              ? '0 : w_rd_top;
    assign bus.nos       = (r_count < CW'(2))   ? '0 : w_rd_nos;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule : operand_stack
`default_nettype wire

// File: doc/operand_stack.md
# operand_stack

Hardware operand stack for the 8-bit multicycle stack processor. Sits directly downstream of the control unit: consumes its `push`, `pop` and `stack_src` strobes, selects write data from the ALU result or the memory data register, and returns the top-of-stack value (`tos`) that feeds the A/B operand registers, the memory write-data path and the `jz` zero test. Also reports depth and sticky overflow/underflow errors for debug and verification.

## Interface
- `DEPTH`, 8: number of entries; power of two, minimum 2.
- `WIDTH`, 8: data width in bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset. Low clears all state immediately, regardless of `clk`.
- `push`  in  1  write the selected data as the new top this cycle.
- `pop`  in  1  remove the current top this cycle.
- `stack_src`  in  1  push data select: 0 = `alu_result`, 1 = `mdr_data`.
- `alu_result`  in  WIDTH  ALU output.
- `mdr_data`  in  WIDTH  memory data register output.
- `err_clr`  in  1  synchronous clear of `overflow` and `underflow`.
- `tos`  out  WIDTH  current top entry; combinational from storage; 0 when empty.
- `nos`  out  WIDTH  entry below top; 0 when count < 2.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky; push rejected because the stack was full.
- `underflow`  out  1  sticky; pop rejected because the stack was empty.

## Operation
- Storage: DEPTH×WIDTH register array plus the `count` register. Entry index `count-1` is the top.
- Write data: `wdata = stack_src ? mdr_data : alu_result`.
- `push` only:
  - If not full: write `wdata` to entry `count`, then `count+1`.
  - If full: no storage change, `count` unchanged, set `overflow`.
- `pop` only:
  - If not empty: `count-1`. The vacated entry keeps its stale value; it is never observable on `tos` or `nos`.
  - If empty: no change, set `underflow`.
- `push` and `pop` together (replace top):
  - If not empty: overwrite entry `count-1` with `wdata`; `count` unchanged; no error, including when full.
  - If empty: behave as a push.
- Neither asserted: hold.
- `err_clr` clears both error flags. If `err_clr` coincides with a new error event in the same cycle, the set wins.
- Read-before-pop: `tos` reflects the pre-edge top during the pop cycle, so the control unit can load A/B from `tos` on the same edge that pops it.

## Timing
- Reset (`reset` low): `count`=0, all entries 0, `overflow`=`underflow`=0. Outputs after reset: `tos`=0, `nos`=0, `empty`=1, `full`=0.
- Asserting `reset` mid-sequence discards all contents immediately (asynchronous). Release is synchronous to the next `clk` edge.
- All state updates happen on the rising edge of `clk`.
- `tos`, `nos`, `empty`, `full` are combinational from registered state; they show the new value in the cycle after the push or pop edge. There are no combinational paths from `push`, `pop` or data inputs to any output.
- Push-to-`tos` latency: 1 cycle.
- Error flags assert in the cycle after the offending edge.

## Structure
- Shared package `stack_pkg` holds:
  - `STACK_DEPTH` and `DATA_W` defaults;
  - `SRC_ALU=1'b0` and `SRC_MDR=1'b1` select constants, also imported by the control unit;
  - a `count_t` typedef.
- Sub-module `stack_regfile`: DEPTH×WIDTH array with one write port (index, data, enable) and two asynchronous read ports (top, next-to-top), reset-cleared.
- `operand_stack` holds `count`, the push/pop/replace decision logic, the error flags and the write-data mux.

## Test plan
- Reset then push `alu_result`=0x12, `stack_src`=0 → next cycle `tos`=0x12, `count`=1, `empty`=0, `nos`=0.
- Push 0x05 (`alu_result`), then push 0x07 (`mdr_data`, `stack_src`=1), then assert pop alone → during the pop cycle `tos`=0x07; after it `tos`=0x05, `count`=1.
- Push 8 values 0x01..0x08, then a ninth push of 0xFF → `full`=1, `tos`=0x08, `count`=8, `overflow`=1. Then assert push and pop together with 0xAA → `tos`=0xAA, `count`=8, no new error.
- Pop on an empty stack → `underflow`=1, `count`=0, `tos`=0. `err_clr` next cycle → `underflow`=0. `err_clr` asserted together with a fresh underflow → flag stays 1.
- Push 0x00 then 0x03, then drive `reset` low between clock edges → `count`=0 and `tos`=0 immediately, before the next edge; release reset, push 0x09 → `tos`=0x09, `nos`=0.
